// File: rtl/ifetch_buffer.sv
// Instruction fetch unit: owns the fetch PC, issues valid/addr_ok/data_ok bus requests and queues up to DEPTH words.
// Data reaches decode 1 cycle after data_ok. Issue is throttled by queue space, and redirect flushes the queue.
module ifetch_buffer #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [PC_W-1:0] ireq_addr,
    input  logic            iresp_addr_ok,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN_REQ, DRAIN} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    state_t          state, state_next;
    logic [PC_W-1:0] fpc, fpc_next, req_pc;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            pop, push, load_req, in_flight, space;
    logic [CW:0]     occupancy;

    assign pop       = out_valid && out_ready;
    assign in_flight = (state == REQ) || (state == WAIT);
    // Reserve a slot for the request still in flight so the queue never overflows.
    assign occupancy = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, in_flight};
    assign space     = occupancy < DEPTH_V;

    assign ireq_valid = (state == REQ) || (state == DRAIN_REQ);
    assign ireq_addr  = req_pc;
    assign out_valid  = (count != '0);
    assign out_pc     = mem[head].pc;
    assign out_instr  = mem[head].instr;

    always_comb begin
        state_next = state;
        fpc_next   = fpc;
        load_req   = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && space) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                end
            end
            REQ: begin
                if (iresp_addr_ok) begin
                    if (redirect_valid) begin
                        state_next = iresp_data_ok ? IDLE : DRAIN;
                    end else begin
                        fpc_next = fpc + PC_W'(4);
                        if (iresp_data_ok) begin
                            push = 1'b1;
                            if (space) begin
                                state_next = REQ;
                                load_req   = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end else if (redirect_valid) begin
                    state_next = DRAIN_REQ;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = iresp_data_ok ? IDLE : DRAIN;
                end else if (iresp_data_ok) begin
                    push = 1'b1;
                    if (space) begin
                        state_next = REQ;
                        load_req   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            // A stale request still completes its bus handshake even if another redirect arrives.
            DRAIN_REQ: begin
                if (iresp_addr_ok) begin
                    state_next = iresp_data_ok ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (iresp_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect_valid) begin
            fpc_next = {redirect_pc[PC_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            fpc    <= RESET_PC;
            req_pc <= RESET_PC;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            fpc   <= fpc_next;
            if (load_req) begin
                req_pc <= fpc_next;
            end
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: req_pc, instr: iresp_data};
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        ireq_valid && !iresp_addr_ok |=> ireq_valid && $stable(ireq_addr));
    assert property (@(posedge clk) disable iff (!reset) {1'b0, count} <= DEPTH_V);

endmodule

// File: doc/ifetch_buffer.md
# ifetch_buffer

Parametrised instruction-fetch unit with a prefetch queue. It replaces the bare PC register and direct `ireq`/`iresp` wiring in the core: it owns the fetch PC, drives the instruction bus with a proper valid/addr_ok/data_ok handshake, and buffers up to DEPTH fetched instructions. It hands them to decode through a valid/ready interface and supports redirect (branch/jump) with flush of stale data.

## Interface
- `DEPTH`, default 4: queue entries; power of two, minimum 2.
- `PC_W`, default 64: PC/address width.
- `RESET_PC`, default 64'h8000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ireq_valid`  out  1  fetch request valid.
- `ireq_addr`  out  PC_W  fetch address; bits [1:0] always 0.
- `iresp_addr_ok`  in  1  bus accepted the request this cycle.
- `iresp_data_ok`  in  1  read data returned this cycle; may coincide with `addr_ok`.
- `iresp_data`  in  32  instruction word, valid with `data_ok`.
- `redirect_valid`  in  1  one-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  PC_W  new fetch PC; bits [1:0] are ignored and forced to 0.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `out_pc`  out  PC_W  PC of head instruction.
- `out_instr`  out  32  head instruction.

## Operation
- Registers: `fpc` (next address to issue), `req_pc` (address of the in-flight request), circular queue with `head`/`tail` ptrs of $clog2(DEPTH) bits that wrap modulo DEPTH, and `count` of $clog2(DEPTH)+1 bits.
- FSM states: IDLE, REQ, WAIT, DRAIN_REQ, DRAIN.
- `space` = count − pop + (REQ/WAIT in flight ? 1 : 0) < DEPTH. An issue only starts when this holds, so the queue never overflows.
- IDLE: if `space`, set `req_pc`=`fpc` and go to REQ.
- REQ: `ireq_valid`=1, `ireq_addr`=`req_pc`, held stable until `addr_ok`.
  - On `addr_ok`: `fpc`+=4.
  - With `addr_ok`&`data_ok`: push, then go to REQ at the new `fpc` if space, else IDLE.
  - With `addr_ok` only: go to WAIT.
- WAIT: on `data_ok`, push {`req_pc`, data}. Then go to REQ at `fpc` if space, else IDLE.
- Redirect has priority over all other events in the same cycle:
  - Queue flushes: `count`=0 and head=tail=0. Any same-cycle pop or push is discarded.
  - `fpc`=`redirect_pc`&~3.
  - IDLE goes to IDLE.
  - REQ without `addr_ok` goes to DRAIN_REQ. A request, once asserted, is never withdrawn.
  - REQ with `addr_ok` and without `data_ok` goes to DRAIN.
  - REQ with both goes to IDLE.
  - WAIT without `data_ok` goes to DRAIN; WAIT with `data_ok` goes to IDLE.
  - DRAIN_REQ or DRAIN: stay in the current state, with only `fpc` updated.
- DRAIN_REQ: `ireq_valid`=1 with the stale `req_pc`. On `addr_ok`&`data_ok` go to IDLE. On `addr_ok` only go to DRAIN. `fpc` is not incremented.
- DRAIN: on `data_ok` the data is discarded and the FSM goes to IDLE.
- Push and pop in the same cycle, including when full, leave `count` unchanged.
- `out_pc`/`out_instr` come from the head entry and are don't-care when `out_valid`=0.
- `out_valid` = (`count` != 0). Outputs do not depend combinationally on `iresp_*`.

## Timing
- Reset (async assert) values:
  - state IDLE, `ireq_valid`=0, `ireq_addr`=RESET_PC, `fpc`=RESET_PC.
  - `out_valid`=0, `count`=0, ptrs 0.
- Reset asserted mid-operation aborts any in-flight request. No drain is performed.
- First edge after reset release: IDLE goes to REQ. `ireq_valid` rises in cycle 1.
- Pushed data becomes visible at the head (`out_valid`=1) the cycle after `data_ok`.
- Zero-wait bus (`addr_ok`&`data_ok` in the same cycle as valid) with `out_ready`=1: sustained throughput is 1 instruction/cycle.
- Redirect takes effect in the next cycle: `out_valid`=0. The earliest new request is 1 cycle later from IDLE.

## Test plan
- Zero-wait bus, `out_ready`=1, after reset release:
  - Addresses 8000_0000, _0004, _0008 are issued on consecutive cycles.
  - Outputs appear in order with PC/instr matching, one per cycle after a 2-cycle latency.
- `out_ready`=0, DEPTH=4, zero-wait bus:
  - Exactly 4 requests issue, then `ireq_valid`=0 and `count`=4.
  - Raising `out_ready` resumes issue with no entry lost or duplicated.
- `addr_ok` delayed 3 cycles:
  - `ireq_addr` is held at 8000_0000 with `ireq_valid`=1 throughout.
  - `data_ok` 2 cycles after `addr_ok` pushes one entry.
- Redirect to 8000_0103 while in WAIT (data pending):
  - The stale `data_ok` word is dropped and the queue is empty.
  - The next request address is 8000_0100.
- Redirect during REQ before `addr_ok`:
  - The stale address stays on the bus until `addr_ok`; its data is discarded.
  - A same-cycle pop/push is discarded.
  - Reset asserted mid-WAIT forces all outputs to their reset values immediately.
